// File: rtl/pico_seq_pkg.sv
// pico_seq_pkg: shared types and constants for the instruction sequencer.
//   state_e        : sequencer FSM states
//   LOAD_EN        : bit of the core's input byte that enables instruction loading
//   DEFAULT_DEPTH  : default instruction buffer depth
//   INSTR_W/BYTE_W : instruction and byte widths
//   force_load()   : returns an instruction word with its load-enable bit set
package pico_seq_pkg;

    localparam int INSTR_W       = 16;
    localparam int BYTE_W        = 8;
    localparam int LOAD_EN       = 7;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_EXEC,
        ST_CAP
    } state_e;

    // The lo byte travels on the load-enable lane, so its top bit is always 1
    // on the wire whatever the buffered word held.
    function automatic logic [INSTR_W-1:0] force_load(input logic [INSTR_W-1:0] w);
        logic [INSTR_W-1:0] r;
        r          = w;
        r[LOAD_EN] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// seq_fifo: instruction buffer, DEPTH entries (power of two, >= 2).
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   push, push_data : write request and word; ignored while full
//   pop             : remove head entry; ignored while empty
//   head            : current head entry (valid when not empty)
//   full, empty     : occupancy flags
//   count           : current occupancy, 0..DEPTH
module seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers 16-bit instructions and feeds them to the core one
// at a time as lo byte, hi byte, execute, capture (4 cycles per instruction).
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data      : push one instruction {hi byte, lo byte}
//   full, empty, count  : buffer status
//   start               : begin draining the buffer into the core
//   halt                : stop after the instruction in flight
//   busy                : FSM is not IDLE
//   drv_ui, drv_uio     : bytes driven into the core
//   tgt_uo, tgt_uio     : core result byte and debug byte {pc[4:0], rd}
//   res_valid           : one-cycle strobe when res_data/res_dbg are updated
//   res_data, res_dbg   : captured core outputs, held until the next capture
//   err                 : sticky; overflow push or lo byte with bit 7 clear
module instr_sequencer
    import pico_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [INSTR_W-1:0]      wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    start,
    input  logic                    halt,
    output logic                    busy,
    output logic [BYTE_W-1:0]       drv_ui,
    output logic [BYTE_W-1:0]       drv_uio,
    input  logic [BYTE_W-1:0]       tgt_uo,
    input  logic [BYTE_W-1:0]       tgt_uio,
    output logic                    res_valid,
    output logic [BYTE_W-1:0]       res_data,
    output logic [BYTE_W-1:0]       res_dbg,
    output logic                    err
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   cur_q, cur_d;
    logic                 halt_q, halt_d;
    logic                 res_valid_q, res_valid_d;
    logic [BYTE_W-1:0]    res_data_q, res_data_d;
    logic [BYTE_W-1:0]    res_dbg_q, res_dbg_d;
    logic                 err_q, err_d;
    logic                 pop;
    logic [INSTR_W-1:0]   head;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_dbg   = res_dbg_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        halt_d      = halt_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_dbg_d   = res_dbg_q;
        err_d       = err_q;
        pop         = 1'b0;
        drv_ui      = '0;
        drv_uio     = '0;

        // A push while full is dropped; a push with bit 7 clear is accepted
        // but flagged. Either way the error is sticky until reset.
        if (wr_en && (full || !wr_data[LOAD_EN])) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !empty) begin
                    pop     = 1'b1;
                    cur_d   = force_load(head);
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                drv_ui  = cur_q[BYTE_W-1:0];
                state_d = ST_HI;
            end
            ST_HI: begin
                drv_ui[LOAD_EN] = 1'b1;
                drv_uio         = cur_q[INSTR_W-1:BYTE_W];
                state_d         = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                res_valid_d = 1'b1;
                res_data_d  = tgt_uo;
                res_dbg_d   = tgt_uio;
                // halt arriving in this very cycle also counts as seen.
                if (halt_q || halt || empty) begin
                    state_d = ST_IDLE;
                end else begin
                    pop     = 1'b1;
                    cur_d   = force_load(head);
                    state_d = ST_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // halt is only remembered while a drain is in progress.
        if (state_q != ST_IDLE && halt) begin
            halt_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            halt_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_dbg_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            halt_q      <= halt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_dbg_q   <= res_dbg_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [15:0]   wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          start;
    logic          halt;
    logic          busy;
    logic [7:0]    drv_ui;
    logic [7:0]    drv_uio;
    logic [7:0]    tgt_uo;
    logic [7:0]    tgt_uio;
    logic          res_valid;
    logic [7:0]    res_data;
    logic [7:0]    res_dbg;
    logic          err;

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .start     (start),
        .halt      (halt),
        .busy      (busy),
        .drv_ui    (drv_ui),
        .drv_uio   (drv_uio),
        .tgt_uo    (tgt_uo),
        .tgt_uio   (tgt_uio),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_dbg   (res_dbg),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Simple core: a byte with bit 7 set loads lo then hi; the first cycle
    // with bit 7 clear after both loads executes. Result = hi byte,
    // debug = {pc, lo[2:0]}, pc counts executed instructions.
    logic [7:0] core_lo, core_hi, core_res, core_dbg;
    logic [1:0] core_ph;
    logic [4:0] core_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_lo  <= '0;
            core_hi  <= '0;
            core_res <= '0;
            core_dbg <= '0;
            core_ph  <= '0;
            core_pc  <= '0;
        end else if (drv_ui[7]) begin
            if (core_ph == 2'd0) begin
                core_lo <= drv_ui;
                core_ph <= 2'd1;
            end else if (core_ph == 2'd1) begin
                core_hi <= drv_uio;
                core_ph <= 2'd2;
            end
        end else if (core_ph == 2'd2) begin
            core_res <= core_hi;
            core_dbg <= {core_pc, core_lo[2:0]};
            core_pc  <= core_pc + 5'd1;
            core_ph  <= 2'd0;
        end
    end

    assign tgt_uo  = core_res;
    assign tgt_uio = core_dbg;

    // Reference model and scoreboard.
    typedef struct {
        logic [7:0] d;
        logic [7:0] g;
    } res_t;

    logic [15:0] mq[$];
    res_t        exp_q[$];
    int          res_cycles[$];
    logic [4:0]  mpc;
    bit          merr;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (res_valid) begin
            res_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_res_valid: got data=0x%0h dbg=0x%0h, required no strobe",
                         res_data, res_dbg);
            end else begin
                e = exp_q.pop_front();
                check("res_data", res_data, e.d);
                check("res_dbg", res_dbg, e.g);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        res_cycles.delete();
        mpc  = '0;
        merr = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        if (!w[7]) merr = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(w);
        else merr = 1'b1;
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic add_exp(input logic [15:0] w);
        res_t e;
        e.d = w[15:8];
        e.g = {mpc, w[2:0]};
        exp_q.push_back(e);
        mpc = mpc + 5'd1;
    endtask

    // Expect the first n buffered words to execute, then pulse start.
    task automatic go(input int n);
        for (int i = 0; i < n; i++) add_exp(mq.pop_front());
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 500) begin
            tick();
            k++;
        end
        check("idle_within_bound", busy, 0);
        tick();
        tick();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) != 0) w[7] = 1'b1;
        return w;
    endfunction

    initial begin
        int nb;
        int n;
        logic [15:0] w1;
        logic [15:0] w2;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; halt = 1'b0;
        mpc = '0; merr = 1'b0;
        tick();
        tick();
        // Reset state.
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);
        check("rst_drv_ui", drv_ui, 0);
        check("rst_drv_uio", drv_uio, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_dbg", res_dbg, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Single instruction: byte sequence on the core interface.
        push(16'h0585);
        tick(); tick();
        check("no_autostart_busy", busy, 0);
        check("one_count", count, 1);
        go(1);
        check("lo_drv_ui", drv_ui, 8'h85);  check("lo_drv_uio", drv_uio, 8'h00);
        tick();
        check("hi_drv_ui", drv_ui, 8'h80);  check("hi_drv_uio", drv_uio, 8'h05);
        tick();
        check("ex_drv_ui", drv_ui, 8'h00);  check("ex_drv_uio", drv_uio, 8'h00);
        tick();
        check("cap_drv_ui", drv_ui, 8'h00); check("cap_drv_uio", drv_uio, 8'h00);
        check("cap_busy", busy, 1);
        wait_idle();
        check("single_err", err, 0);

        // Three instructions, one start pulse: 12 busy cycles, strobes 4 apart.
        res_cycles.delete();
        for (int i = 0; i < 3; i++) push(rand_word() | 16'h0080);
        go(3);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            tick();
        end
        check("busy_cycles", nb, 12);
        tick(); tick();
        check("three_strobes", res_cycles.size(), 3);
        if (res_cycles.size() == 3) begin
            check("strobe_gap1", res_cycles[1] - res_cycles[0], 4);
            check("strobe_gap2", res_cycles[2] - res_cycles[1], 4);
        end
        check("three_empty", empty, 1);

        // Lo byte with bit 7 clear: forced on the wire, err set.
        push(16'h0005);
        check("bit7_err", err, 1);
        go(1);
        check("bit7_lo_drv", drv_ui, 8'h85);
        wait_idle();

        // Overflow: DEPTH+1 pushes.
        do_reset();
        res_cycles.delete();
        for (int i = 0; i < DEPTH + 1; i++) push(rand_word() | 16'h0080);
        check("ovf_full", full, 1);
        check("ovf_count", count, DEPTH);
        check("ovf_err", err, 1);
        go(DEPTH);
        wait_idle();
        check("ovf_results", res_cycles.size(), DEPTH);
        check("ovf_empty", empty, 1);

        // Halt during the first HI stops after one result.
        do_reset();
        for (int i = 0; i < 4; i++) push(rand_word() | 16'h0080);
        go(1);
        tick();
        check("halt_in_hi", drv_ui, 8'h80);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_idle();
        check("halt_count", count, 3);
        check("halt_busy", busy, 0);
        // halt in IDLE is ignored; the remaining three all run.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("idle_halt_busy", busy, 0);
        go(3);
        wait_idle();
        check("halt_drain_empty", empty, 1);

        // Simultaneous push and pop keeps count; both words execute.
        do_reset();
        w1 = rand_word() | 16'h0080;
        w2 = rand_word() | 16'h0080;
        push(w1);
        add_exp(w1);
        add_exp(w2);
        mq.delete();
        wr_en = 1'b1; wr_data = w2; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("pushpop_count", count, 1);
        wait_idle();
        check("pushpop_drained", count, 0);

        // Reset during EXEC of the second of three instructions.
        do_reset();
        for (int i = 0; i < 3; i++) push(rand_word() | 16'h0080);
        go(1);
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_drv_ui", drv_ui, 0);
        check("mid_rst_drv_uio", drv_uio, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_first_result_seen", exp_q.size(), 0);
        tick();
        rst = 1'b0;
        mq.delete(); exp_q.delete(); mpc = '0; merr = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("mid_rst_idle", busy, 0);

        // Randomized fill-and-drain rounds.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) push(rand_word());
            check("rand_count", count, mq.size());
            check("rand_err", err, merr);
            go(mq.size());
            wait_idle();
            check("rand_empty", empty, 1);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  push request for one 16-bit instruction.
REQ-005 SHALL have port wr_data  input  16  instruction word {hi byte, lo byte}.
REQ-006 SHALL have port full  output  1  buffer holds DEPTH entries.
REQ-007 SHALL have port empty  output  1  buffer holds 0 entries.
REQ-008 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-009 SHALL have port start  input  1  begin draining the buffer into the core.
REQ-010 SHALL have port halt  input  1  stop after the instruction in flight.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port drv_ui  output  8  drives the core's dedicated input byte.
REQ-013 SHALL have port drv_uio  output  8  drives the core's bidirectional input byte.
REQ-014 SHALL have port tgt_uo  input  8  core's result byte.
REQ-015 SHALL have port tgt_uio  input  8  core's debug byte {pc[4:0], rd}.
REQ-016 SHALL have port res_valid  output  1  one-cycle strobe, result captured.
REQ-017 SHALL have port res_data  output  8  captured tgt_uo.
REQ-018 SHALL have port res_dbg  output  8  captured tgt_uio.
REQ-019 SHALL have port err  output  1  sticky: overflow push or lo-byte bit7 was 0.

Function
REQ-020 SHALL implement FSM states IDLE, LO, HI, EXEC, CAP; one instruction occupies exactly 4 cycles.
REQ-021 IDLE: drv_ui=0x00, drv_uio=0x00; start=1 and not empty -> LO, popping head into a current-instruction register; start while empty stays IDLE.
REQ-022 LO: drv_ui = {1'b1, cur[6:0]}, drv_uio=0x00; -> HI.
REQ-023 HI: drv_ui=0x80, drv_uio=cur[15:8]; -> EXEC.
REQ-024 EXEC: drv_ui=0x00 (load enable low, core executes), drv_uio=0x00; -> CAP.
REQ-025 CAP: drv outputs 0x00; at the closing edge register tgt_uo->res_data, tgt_uio->res_dbg, assert res_valid for the following cycle only.
REQ-026 CAP exit: halt seen since last start, or empty -> IDLE; else -> LO with a pop of the next entry.
REQ-027 drv_ui/drv_uio SHALL be decoded only from registered state and cur, never from inputs.
REQ-028 Instruction with wr_data[7]=0 SHALL be accepted, transmitted with bit7 forced to 1, and set err.
REQ-029 Push SHALL be accepted when not full at the edge; push while full SHALL be dropped and set err.
REQ-030 Simultaneous accepted push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-031 Push accepted while empty during IDLE SHALL not start execution without start.
REQ-032 halt in IDLE SHALL have no effect; halt is latched until the FSM returns to IDLE.
REQ-033 res_data/res_dbg SHALL hold their value until the next capture.

Reset
REQ-034 rst SHALL asynchronously force IDLE, empty buffer, count=0, full=0, empty=1, busy=0, drv_ui=0x00, drv_uio=0x00, res_valid=0, res_data=0x00, res_dbg=0x00, err=0, halt latch cleared.
REQ-035 rst mid-instruction SHALL discard the in-flight and buffered instructions; no res_valid follows.

Structure
REQ-036 Package pico_seq_pkg SHALL hold the state enum, LOAD_EN bit index (7), default DEPTH, instruction/byte widths.
REQ-037 Buffer SHALL be sub-module seq_fifo (push/pop, full/empty/count); FSM and drivers stay in instr_sequencer.

Verification
REQ-038 Push 0x0585, start -> drv_ui 0x85, 0x80, 0x00, 0x00 on 4 consecutive cycles; drv_uio 0x00, 0x05, 0x00, 0x00; res_valid once, res_data = tgt_uo (0x05 with core model).
REQ-039 Push 3 words, start pulse -> 12 busy cycles, 3 res_valid strobes 4 cycles apart, then IDLE, empty=1.
REQ-040 Push DEPTH+1 words -> full=1, count=DEPTH, last word dropped, err=1; draining yields exactly DEPTH results.
REQ-041 Push 0x0005 (bit7=0) -> LO drives 0x85, err=1.
REQ-042 Push 4, start, halt during first HI -> exactly 1 result, IDLE, count=3.
REQ-043 Assert rst during EXEC of second of 3 instructions -> drv 0x00 immediately, count=0, no further res_valid.
